// File: rtl/pe_cfg_ctrl.sv
// pe_cfg_ctrl: configuration sequencer for the PE array.
// Clears the array, streams instruction words into each PE's configuration
// buffer (PE-major order, one-hot init strobe per word), then broadcasts run
// for a clamped number of cycles and pulses done.
module pe_cfg_ctrl #(
    parameter int NUM_PE = 16,
    parameter int INST_W = 48,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 5,
    parameter int RUN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [RUN_W-1:0]  run_len,
    input  logic              cfg_valid,
    input  logic [INST_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              pe_rst,
    output logic [NUM_PE-1:0] pe_init,
    output logic [INST_W-1:0] pe_inst,
    output logic              pe_run,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                IDX_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [RUN_W-1:0]  DEPTH_RUN = RUN_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_PE   = IDX_W'(NUM_PE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAIN,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]  cfg_len_q;
    logic [LEN_W-1:0]  ctx_idx;
    logic [IDX_W-1:0]  pe_idx;
    logic [RUN_W-1:0]  run_len_q;
    logic [RUN_W-1:0]  run_cnt;
    logic [NUM_PE-1:0] pe_init_q;
    logic [INST_W-1:0] pe_inst_q;
    logic              err_q;

    logic cfg_len_ok;
    logic start_acc;
    logic xfer;
    logic last_ctx;
    logic last_pe;
    logic run_last;

    assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= DEPTH_LEN);
    assign start_acc  = (state == S_IDLE) && start && !abort;
    assign xfer       = (state == S_LOAD) && cfg_valid;
    assign last_ctx   = (ctx_idx == (cfg_len_q - 1'b1));
    assign last_pe    = (pe_idx == LAST_PE);
    assign run_last   = (run_cnt == (run_len_q - 1'b1));

    // Control outputs are decoded straight from the state so they drop the
    // cycle after an abort or reset without any extra clearing logic.
    assign cfg_ready = (state == S_LOAD);
    assign pe_rst    = (state == S_CLEAR);
    assign pe_run    = (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign pe_init   = pe_init_q;
    assign pe_inst   = pe_inst_q;
    assign err       = err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_acc && cfg_len_ok) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_LOAD;
            S_LOAD:  if (xfer && last_ctx && last_pe) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = (run_len_q == '0) ? S_DONE : S_RUN;
            S_RUN:   if (run_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Job parameters, load position counters, registered strobe/bus and run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_len_q <= '0;
            run_len_q <= '0;
            ctx_idx   <= '0;
            pe_idx    <= '0;
            run_cnt   <= '0;
            pe_init_q <= '0;
            pe_inst_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q     <= start_acc && !cfg_len_ok;
            pe_init_q <= '0;
            run_cnt   <= (state == S_RUN) ? run_cnt + 1'b1 : '0;

            if (start_acc && cfg_len_ok) begin
                cfg_len_q <= cfg_len;
                run_len_q <= (run_len > DEPTH_RUN) ? DEPTH_RUN : run_len;
                ctx_idx   <= '0;
                pe_idx    <= '0;
            end

            if (abort && (state != S_IDLE)) begin
                pe_inst_q <= '0;
            end else if (xfer) begin
                pe_init_q <= NUM_PE'(1) << pe_idx;
                pe_inst_q <= cfg_data;
                if (last_ctx) begin
                    ctx_idx <= '0;
                    pe_idx  <= pe_idx + 1'b1;
                end else begin
                    ctx_idx <= ctx_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_cfg_ctrl.sv
// tb_pe_cfg_ctrl: randomized self-checking bench for pe_cfg_ctrl against a
// word-count based behavioural model, plus literal expectations per scenario.
module tb_pe_cfg_ctrl;

    localparam int NUM_PE = 16;
    localparam int INST_W = 48;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 5;
    localparam int RUN_W  = 16;
    localparam int WAIT_LIMIT = 3000;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [LEN_W-1:0]  cfg_len;
    logic [RUN_W-1:0]  run_len;
    logic              cfg_valid;
    logic [INST_W-1:0] cfg_data;
    logic              cfg_ready;
    logic              pe_rst;
    logic [NUM_PE-1:0] pe_init;
    logic [INST_W-1:0] pe_inst;
    logic              pe_run;
    logic              busy;
    logic              done;
    logic              err;

    pe_cfg_ctrl #(
        .NUM_PE(NUM_PE), .INST_W(INST_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .RUN_W(RUN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_len(cfg_len), .run_len(run_len),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .pe_rst(pe_rst), .pe_init(pe_init), .pe_inst(pe_inst), .pe_run(pe_run),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Valid pattern: 0 held high, 1 toggling, 2 random.
    int vmode = 0;
    int poke_en = 0;
    int abort_en = 0;

    // Observation counters taken from the DUT, compared against literals.
    int obs_rst, obs_init, obs_run, obs_done, obs_err, obs_busy;
    logic [NUM_PE-1:0] first_init, last_init;

    // Behavioural model: job progress tracked as words accepted and run cycles left.
    typedef enum {M_IDLE, M_CLEAR, M_LOAD, M_DRAIN, M_RUN, M_DONE} mphase_t;
    mphase_t           m_ph = M_IDLE;
    int                m_len = 1;
    int                m_runeff = 0;
    int                m_words = 0;
    int                m_run_left = 0;
    logic [NUM_PE-1:0] e_init = '0;
    logic [INST_W-1:0] e_inst = '0;
    logic              e_err = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic a, input int len, input int rl);
        start   = s;
        abort   = a;
        cfg_len = LEN_W'(len);
        run_len = RUN_W'(rl);
    endtask

    task automatic clearObs();
        obs_rst = 0; obs_init = 0; obs_run = 0; obs_done = 0; obs_err = 0; obs_busy = 0;
        first_init = '0; last_init = '0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples.
    task automatic modelStep();
        if (rst) begin
            m_ph = M_IDLE; e_err = 1'b0; e_init = '0; e_inst = '0;
            m_words = 0; m_run_left = 0;
        end else begin
            e_err  = 1'b0;
            e_init = '0;
            if (m_ph == M_IDLE) begin
                if (start && !abort) begin
                    if (cfg_len == 0 || int'(cfg_len) > DEPTH) begin
                        e_err = 1'b1;
                    end else begin
                        m_len    = int'(cfg_len);
                        m_runeff = (int'(run_len) > DEPTH) ? DEPTH : int'(run_len);
                        m_words  = 0;
                        m_ph     = M_CLEAR;
                    end
                end
            end else if (abort) begin
                m_ph   = M_IDLE;
                e_inst = '0;
            end else begin
                case (m_ph)
                    M_CLEAR: m_ph = M_LOAD;
                    M_LOAD: begin
                        if (cfg_valid) begin
                            e_init = NUM_PE'(64'd1 << (m_words / m_len));
                            e_inst = cfg_data;
                            m_words++;
                            if (m_words == m_len * NUM_PE) m_ph = M_DRAIN;
                        end
                    end
                    M_DRAIN: begin
                        m_run_left = m_runeff;
                        m_ph = (m_runeff == 0) ? M_DONE : M_RUN;
                    end
                    M_RUN: begin
                        m_run_left--;
                        if (m_run_left == 0) m_ph = M_DONE;
                    end
                    default: m_ph = M_IDLE;
                endcase
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("cfg_ready", 64'(cfg_ready), 64'(m_ph == M_LOAD));
        checkOutput("pe_rst",    64'(pe_rst),    64'(m_ph == M_CLEAR));
        checkOutput("pe_run",    64'(pe_run),    64'(m_ph == M_RUN));
        checkOutput("busy",      64'(busy),      64'(m_ph != M_IDLE));
        checkOutput("done",      64'(done),      64'(m_ph == M_DONE));
        checkOutput("err",       64'(err),       64'(e_err));
        checkOutput("pe_init",   64'(pe_init),   64'(e_init));
        checkOutput("pe_inst",   64'(pe_inst),   64'(e_inst));
    endtask

    // Model update on each edge, then compare and observe away from the edge.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            #2;
            compareAll();
            obs_rst  += int'(pe_rst);
            obs_run  += int'(pe_run);
            obs_done += int'(done);
            obs_err  += int'(err);
            obs_busy += int'(busy);
            if (pe_init != '0) begin
                if (obs_init == 0) first_init = pe_init;
                last_init = pe_init;
                obs_init++;
            end
        end
    end

    // Upstream source: fresh random word every cycle, valid per the selected pattern.
    initial begin
        cfg_valid = 1'b0;
        cfg_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            case (vmode)
                0:       cfg_valid = 1'b1;
                1:       cfg_valid = !cfg_valid;
                default: cfg_valid = 1'($urandom_range(0, 1));
            endcase
            cfg_data = {16'($urandom), 32'($urandom)};
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (busy === 1'b1 && n < WAIT_LIMIT) begin
            start = (poke_en != 0) && ($urandom_range(0, 15) == 0);
            abort = (abort_en != 0) && ($urandom_range(0, 199) == 0);
            step();
            n++;
        end
        start = 1'b0;
        abort = 1'b0;
        checkOutput("idle_timeout", 64'(n >= WAIT_LIMIT), 64'(0));
    endtask

    task automatic runJob(input int len, input int rl);
        applyStimulus(1'b1, 1'b0, len, rl);
        step();
        applyStimulus(1'b0, 1'b0, len, rl);
        waitIdle();
    endtask

    initial begin
        int n;
        int k;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 0);
        clearObs();
        repeat (3) step();

        // Reset state.
        checkOutput("rst_busy",    64'(busy),    64'(0));
        checkOutput("rst_pe_init", 64'(pe_init), 64'(0));
        checkOutput("rst_pe_inst", 64'(pe_inst), 64'(0));
        checkOutput("rst_pe_run",  64'(pe_run),  64'(0));
        checkOutput("rst_ready",   64'(cfg_ready), 64'(0));
        rst = 1'b0;
        step();

        // Full job, valid held high.
        $display("[TB] job cfg_len=3 run_len=5, valid held high");
        vmode = 0;
        clearObs();
        runJob(3, 5);
        checkOutput("t1_pe_rst_cycles", 64'(obs_rst), 64'(1));
        checkOutput("t1_strobes",       64'(obs_init), 64'(48));
        checkOutput("t1_first_init",    64'(first_init), 64'h0001);
        checkOutput("t1_last_init",     64'(last_init), 64'h8000);
        checkOutput("t1_run_cycles",    64'(obs_run), 64'(5));
        checkOutput("t1_done_pulses",   64'(obs_done), 64'(1));

        // Same job, valid toggling.
        $display("[TB] job cfg_len=3 run_len=5, valid toggling");
        vmode = 1;
        clearObs();
        runJob(3, 5);
        checkOutput("t2_strobes",    64'(obs_init), 64'(48));
        checkOutput("t2_run_cycles", 64'(obs_run), 64'(5));

        // Rejected starts.
        $display("[TB] rejected starts");
        clearObs();
        applyStimulus(1'b1, 1'b0, 0, 5);
        step();
        applyStimulus(1'b0, 1'b0, 0, 5);
        step();
        applyStimulus(1'b1, 1'b0, 17, 5);
        step();
        applyStimulus(1'b0, 1'b0, 17, 5);
        step();
        checkOutput("t3_err_pulses", 64'(obs_err), 64'(2));
        checkOutput("t3_busy_cycles", 64'(obs_busy), 64'(0));
        checkOutput("t3_pe_rst", 64'(obs_rst), 64'(0));

        // Full depth with clamped run, then zero run length.
        $display("[TB] cfg_len=16 run_len=40, then run_len=0");
        vmode = 0;
        clearObs();
        runJob(16, 40);
        checkOutput("t4_strobes",    64'(obs_init), 64'(256));
        checkOutput("t4_run_clamp",  64'(obs_run), 64'(16));
        clearObs();
        runJob(2, 0);
        checkOutput("t4_run_zero",   64'(obs_run), 64'(0));
        checkOutput("t4_done_zero",  64'(obs_done), 64'(1));

        // Abort after the tenth accepted word.
        $display("[TB] abort mid-load");
        applyStimulus(1'b1, 1'b0, 3, 5);
        step();
        applyStimulus(1'b0, 1'b0, 3, 5);
        n = 0; k = 0;
        while (n < 10 && k < 500) begin
            step();
            k++;
            if (pe_init != '0) n++;
        end
        checkOutput("t5_strobe_wait", 64'(n), 64'(10));
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("t5_busy",    64'(busy),    64'(0));
        checkOutput("t5_pe_init", 64'(pe_init), 64'(0));
        checkOutput("t5_ready",   64'(cfg_ready), 64'(0));
        checkOutput("t5_pe_run",  64'(pe_run),  64'(0));
        checkOutput("t5_done",    64'(done),    64'(0));
        clearObs();
        applyStimulus(1'b1, 1'b0, 2, 5);
        step();
        applyStimulus(1'b0, 1'b0, 2, 5);
        checkOutput("t5_restart_pe_rst", 64'(pe_rst), 64'(1));
        waitIdle();
        checkOutput("t5_restart_strobes", 64'(obs_init), 64'(32));
        checkOutput("t5_restart_done",    64'(obs_done), 64'(1));

        // Reset during the third run cycle, start held across reset release.
        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b0, 2, 5);
        step();
        applyStimulus(1'b0, 1'b0, 2, 5);
        n = 0; k = 0;
        while (n < 3 && k < 500) begin
            step();
            k++;
            if (pe_run) n++;
        end
        checkOutput("t6_run_wait", 64'(n), 64'(3));
        rst = 1'b1;
        step();
        checkOutput("t6_busy",    64'(busy),    64'(0));
        checkOutput("t6_pe_run",  64'(pe_run),  64'(0));
        checkOutput("t6_pe_inst", 64'(pe_inst), 64'(0));
        applyStimulus(1'b1, 1'b0, 2, 5);
        step();
        checkOutput("t6_start_in_rst", 64'(busy), 64'(0));
        rst = 1'b0;
        step();
        applyStimulus(1'b0, 1'b0, 2, 5);
        checkOutput("t6_start_after_rst", 64'(pe_rst), 64'(1));
        waitIdle();

        // Randomized jobs with random valid, stray starts and occasional aborts.
        $display("[TB] randomized jobs");
        vmode = 2;
        poke_en = 1;
        abort_en = 1;
        for (int j = 0; j < 8; j++) begin
            runJob(int'($urandom_range(0, 17)), int'($urandom_range(0, 40)));
            step();
        end
        poke_en = 0;
        abort_en = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
